// File: rtl/parity_check_32.sv
// parity_check_32: receive-side parity checker for a valid/ready word stream.
// Each accepted word is recomputed against its parity bit and forwarded one
// cycle later with a parity-error flag. A small frame FSM accumulates errors
// across a frame and pulses frame_done/frame_err when the last word is taken.
// A saturating counter tracks bad words since reset or the last clear.
module parity_check_32 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_perr,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_count
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Parity error of one word: 0 for a good word under the selected sense.
  function automatic logic calc_perr(input logic [DATA_W-1:0] data,
                                     input logic              parity);
    return (^data) ^ parity ^ ODD;
  endfunction

  // Next value of the error counter: clear wins, otherwise saturating +1.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic             clr,
                                                  input logic             bump);
    logic [CNT_W-1:0] res;
    if (clr) begin
      res = bump ? CNT_W'(1'b1) : {CNT_W{1'b0}};
    end else if (bump && (cur != {CNT_W{1'b1}})) begin
      res = cur + CNT_W'(1'b1);
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic   accept_s;
  logic   perr_s;
  state_t state_r;
  state_t state_next_s;
  logic   acc_r;
  logic   acc_next_s;
  logic   pulse_s;
  logic   ferr_s;

  // Upstream may push whenever the output register is empty or draining.
  assign in_ready = !out_valid | out_ready;
  assign accept_s = in_valid & in_ready;
  assign perr_s   = calc_perr(in_data, in_parity);

  // Frame FSM state register together with the running frame error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      acc_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      acc_r   <= acc_next_s;
    end
  end

  // Frame FSM next state: only an accepted word moves the frame along.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = in_last ? ST_IDLE : ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (accept_s) begin
          state_next_s = in_last ? ST_IDLE : ST_ACTIVE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Frame FSM outputs: accumulator update and the close-of-frame pulse.
  always_comb begin
    acc_next_s = acc_r;
    pulse_s    = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          acc_next_s = in_last ? 1'b0 : perr_s;
          pulse_s    = in_last;
          ferr_s     = perr_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      ST_ACTIVE: begin
        if (accept_s) begin
          acc_next_s = in_last ? 1'b0 : (acc_r | perr_s);
          pulse_s    = in_last;
          ferr_s     = acc_r | perr_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      default: begin
        acc_next_s = 1'b0;
      end
    endcase
  end

  // Output register: load on accept, drop valid when drained, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_last  <= 1'b0;
      out_perr  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_perr  <= perr_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Frame status: one-cycle pulse aligned with the last word appearing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= pulse_s;
      frame_err  <= pulse_s & ferr_s;
    end
  end

  // Cumulative bad-word counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= {CNT_W{1'b0}};
    end else begin
      err_count <= next_count(err_count, clr_count, accept_s & perr_s);
    end
  end

endmodule
